// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-loadable Mealy serial pattern detector with KMP fallback.
// Optional saturating match counter is built only when SEQ_DET_COUNT_EN is defined.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8,
  parameter int               SW      = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [SW-1:0]    pr,
  output logic [SW-1:0]    next,
  output logic [CNT_W-1:0] match_cnt
);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [SW-1:0]    pr_q, pr_d;
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] pfx;
  logic [SW-1:0]    fall;
  logic             full_match;

  // cand holds the k matched prefix bits followed by din, right-aligned (din at bit 0).
  // The longest suffix of cand that is also a pattern prefix is the next state; when the
  // whole pattern matched, the same search (capped at PAT_W-1) yields its longest border.
  always_comb begin
    cand = ((pat_q >> (PAT_W - int'(pr_q))) << 1) | {{(PAT_W-1){1'b0}}, din};
    fall = '0;
    mask = '0;
    pfx  = '0;
    for (int l = 1; l < PAT_W; l++) begin
      mask = {PAT_W{1'b1}} >> (PAT_W - l);
      pfx  = pat_q >> (PAT_W - l);
      if ((l <= int'(pr_q) + 1) && (((cand ^ pfx) & mask) == '0)) begin
        fall = SW'(l);
      end
    end
  end

  assign full_match = (pr_q == SW'(PAT_W - 1)) && (din == pat_q[0]);

  always_comb begin
    dout  = 1'b0;
    pr_d  = pr_q;
    pat_d = pat_q;
    if (rst) begin
      pr_d  = '0;
      pat_d = PATTERN;
    end else if (pat_load) begin
      pr_d  = '0;
      pat_d = pat_in;
    end else if (din_valid) begin
      dout = full_match;
      if (full_match && !overlap) begin
        pr_d = '0;
      end else begin
        pr_d = fall;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_q  <= '0;
      pat_q <= PATTERN;
    end else begin
      pr_q  <= pr_d;
      pat_q <= pat_d;
    end
  end

  assign pr   = pr_q;
  assign next = pr_d;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats a coincident match; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (dout && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed bench for seq_detector_param (counter checks follow SEQ_DET_COUNT_EN).
module tb_seq_detector_param;

`ifdef SEQ_DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;
  logic       dout, dout_s;
  logic [1:0] pr, pr_s, next, next_s;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .dout(dout), .pr(pr), .next(next), .match_cnt(match_cnt)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .dout(dout_s), .pr(pr_s), .next(next_s), .match_cnt(match_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered 1ns after a rising edge; leaves 1ns after the next one.
  task automatic step(input logic b, input logic v, input logic ld, input logic clr,
                      input logic exp_dout, input int exp_pr, input int exp_cnt,
                      input int exp_sat, input string tag);
    din = b; din_valid = v; pat_load = ld; cnt_clr = clr;
    #4;
    check({tag, ".dout"}, 32'(dout), 32'(exp_dout));
    check({tag, ".next"}, 32'(next), 32'(exp_pr));
    check({tag, ".sat_dout"}, 32'(dout_s), 32'(exp_dout));
    @(posedge clk); #1;
    check({tag, ".pr"}, 32'(pr), 32'(exp_pr));
    check({tag, ".cnt"}, 32'(match_cnt), CNT_ON ? 32'(exp_cnt) : 32'd0);
    check({tag, ".sat_cnt"}, 32'(match_cnt_s), CNT_ON ? 32'(exp_sat) : 32'd0);
    pat_load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic rst_cycle(input logic b, input string tag);
    rst = 1'b1; din = b; din_valid = 1'b1;
    #4;
    check({tag, ".dout"}, 32'(dout), 32'd0);
    check({tag, ".next"}, 32'(next), 32'd0);
    @(posedge clk); #1;
    check({tag, ".pr"}, 32'(pr), 32'd0);
    check({tag, ".cnt"}, 32'(match_cnt), 32'd0);
    check({tag, ".sat_cnt"}, 32'(match_cnt_s), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
    @(posedge clk); #1;
    rst_cycle(1'b0, "init");

    // partial match, then reset mid-sequence: the next 1 must start from state 0
    step(1, 1, 0, 0, 0, 1, 0, 0, "pre1");
    step(0, 1, 0, 0, 0, 2, 0, 0, "pre2");
    step(1, 1, 0, 0, 0, 3, 0, 0, "pre3");
    rst_cycle(1'b1, "rst_a");
    rst_cycle(1'b0, "rst_b");
    step(1, 1, 0, 0, 0, 1, 0, 0, "post_rst");
    rst_cycle(1'b1, "rst_c");

    // overlapping: 1,0,1,1,0,1,1
    overlap = 1'b1;
    step(1, 1, 0, 0, 0, 1, 0, 0, "ov1");
    step(0, 1, 0, 0, 0, 2, 0, 0, "ov2");
    step(1, 1, 0, 0, 0, 3, 0, 0, "ov3");
    step(1, 1, 0, 0, 1, 1, 1, 1, "ov4");
    step(0, 1, 0, 0, 0, 2, 1, 1, "ov5");
    step(1, 1, 0, 0, 0, 3, 1, 1, "ov6");
    step(1, 1, 0, 0, 1, 1, 2, 2, "ov7");
    rst_cycle(1'b0, "rst_d");

    // non-overlapping: same stream
    overlap = 1'b0;
    step(1, 1, 0, 0, 0, 1, 0, 0, "no1");
    step(0, 1, 0, 0, 0, 2, 0, 0, "no2");
    step(1, 1, 0, 0, 0, 3, 0, 0, "no3");
    step(1, 1, 0, 0, 1, 0, 1, 1, "no4");
    step(0, 1, 0, 0, 0, 0, 1, 1, "no5");
    step(1, 1, 0, 0, 0, 1, 1, 1, "no6");
    step(1, 1, 0, 0, 0, 1, 1, 1, "no7");
    rst_cycle(1'b0, "rst_e");

    // KMP fallback: 1,0,1,0,1,0,1,1
    overlap = 1'b1;
    step(1, 1, 0, 0, 0, 1, 0, 0, "fb1");
    step(0, 1, 0, 0, 0, 2, 0, 0, "fb2");
    step(1, 1, 0, 0, 0, 3, 0, 0, "fb3");
    step(0, 1, 0, 0, 0, 2, 0, 0, "fb4");
    step(1, 1, 0, 0, 0, 3, 0, 0, "fb5");
    step(0, 1, 0, 0, 0, 2, 0, 0, "fb6");
    step(1, 1, 0, 0, 0, 3, 0, 0, "fb7");
    step(1, 1, 0, 0, 1, 1, 1, 1, "fb8");
    rst_cycle(1'b0, "rst_f");

    // valid gating, then load 0110 alongside a would-be match bit
    step(1, 1, 0, 0, 0, 1, 0, 0, "vg1");
    step(0, 1, 0, 0, 0, 2, 0, 0, "vg2");
    step(1, 0, 0, 0, 0, 2, 0, 0, "vg_hold1");
    step(1, 0, 0, 0, 0, 2, 0, 0, "vg_hold2");
    step(1, 1, 0, 0, 0, 3, 0, 0, "vg3");
    step(1, 0, 0, 0, 0, 3, 0, 0, "vg_hold3");
    pat_in = 4'b0110;
    step(1, 1, 1, 0, 0, 0, 0, 0, "load");
    step(0, 1, 0, 0, 0, 1, 0, 0, "np1");
    step(1, 1, 0, 0, 0, 2, 0, 0, "np2");
    step(1, 1, 0, 0, 0, 3, 0, 0, "np3");
    step(0, 1, 0, 0, 1, 1, 1, 1, "np4");
    rst_cycle(1'b0, "rst_g");

    // five overlapping matches: saturation on the 2-bit counter
    step(1, 1, 0, 0, 0, 1, 0, 0, "sat_a");
    step(0, 1, 0, 0, 0, 2, 0, 0, "sat_b");
    step(1, 1, 0, 0, 0, 3, 0, 0, "sat_c");
    step(1, 1, 0, 0, 1, 1, 1, 1, "sat_m1");
    for (int m = 2; m <= 5; m++) begin
      step(0, 1, 0, 0, 0, 2, m - 1, (m - 1 > 3) ? 3 : m - 1, "sat_x");
      step(1, 1, 0, 0, 0, 3, m - 1, (m - 1 > 3) ? 3 : m - 1, "sat_y");
      step(1, 1, 0, 0, 1, 1, m, (m > 3) ? 3 : m, "sat_m");
    end

    // clear coincident with a match wins, then counting resumes
    step(0, 1, 0, 0, 0, 2, 5, 3, "clr_x");
    step(1, 1, 0, 0, 0, 3, 5, 3, "clr_y");
    step(1, 1, 0, 1, 1, 1, 0, 0, "clr_m");
    step(0, 1, 0, 0, 0, 2, 0, 0, "clr_x2");
    step(1, 1, 0, 0, 0, 3, 0, 0, "clr_y2");
    step(1, 1, 0, 0, 1, 1, 1, 1, "clr_m2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
